pq_req_arbiter: RTL and testbench

//  Shares one priority queue (pq) among NREQ requesters. Each requester issues push/pop/drop

---
 rtl/pq_pkg.sv | 34 +++
 rtl/pq_rr_arb.sv | 32 +++
 rtl/pq_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_pq_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue block: command opcodes, the response
// tag layout and the per-operation legality rule used by the request arbiter.
package pq_pkg;

  localparam int QUEUE_DEPTH = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int PQ_NREQ     = 4;
  localparam int PQ_IDX_W    = $clog2(PQ_NREQ);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_DROP = 2'd3
  } pq_op_e;

  typedef struct packed {
    logic                vld;
    logic [PQ_IDX_W-1:0] idx;
    pq_op_e              op;
  } pq_tag_t;

  // A command may be granted only when the queue can take that operation now.
  function automatic logic op_legal(pq_op_e op, logic push_rdy, logic pop_rdy,
                                    logic drop_rdy, logic empty);
    case (op)
      OP_PUSH: return push_rdy;
      OP_POP:  return pop_rdy & ~empty;
      OP_DROP: return drop_rdy;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pq_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Returns a one-hot grant plus its binary index.
module pq_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/pq_req_arbiter.sv
// Shares one priority queue among NREQ requesters: round-robin command grant
// gated by queue readiness, with a tag pipe that routes responses back.
module pq_req_arbiter
  import pq_pkg::*;
#(
  parameter int NREQ     = PQ_NREQ,
  parameter int DEPTH    = QUEUE_DEPTH,
  parameter int DW       = DATA_WIDTH,
  parameter int RESP_LAT = 1,
  localparam int ID_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_vld_i,
  input  logic [NREQ*2-1:0]  req_op_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ*ID_W-1:0] req_drop_id_i,
  output logic [NREQ-1:0]    req_rdy_o,
  output logic [NREQ-1:0]    rsp_vld_o,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [DW-1:0]      rsp_data_o,
  output logic               pq_push_o,
  output logic               pq_pop_o,
  output logic               pq_drop_o,
  output logic [ID_W-1:0]    pq_drop_id_o,
  output logic [DW-1:0]      pq_data_o,
  input  logic               pq_push_rdy_i,
  input  logic               pq_pop_rdy_i,
  input  logic               pq_drop_rdy_i,
  input  logic               pq_empty_i,
  input  logic [ID_W-1:0]    pq_push_id_i,
  input  logic [DW-1:0]      pq_data_i
);

  localparam int IDX_W = $clog2(NREQ);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    pq_op_e           op;
  } tag_t;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] ptr;
  pq_op_e           gnt_op;
  logic [DW-1:0]    data_sel;
  logic [ID_W-1:0]  drop_sel;
  tag_t             tag_p [RESP_LAT];
  tag_t             tag_tail;
  logic [NREQ-1:0]  rsp_vld_d;
  logic [ID_W-1:0]  rsp_id_d;
  logic [DW-1:0]    rsp_data_d;

  // Grant is gated by reset so nothing leaks out while the block is held in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = rst_ni & req_vld_i[i]
              & op_legal(pq_op_e'(req_op_i[2*i +: 2]), pq_push_rdy_i,
                         pq_pop_rdy_i, pq_drop_rdy_i, pq_empty_i);
    end
  end

  pq_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arb (
    .req   (elig),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

  always_comb begin
    gnt_op   = OP_NONE;
    data_sel = '0;
    drop_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_op   = pq_op_e'(req_op_i[2*i +: 2]);
        data_sel = req_data_i[i*DW +: DW];
        drop_sel = req_drop_id_i[i*ID_W +: ID_W];
      end
    end
  end

  assign req_rdy_o    = gnt;
  assign pq_push_o    = (gnt_op == OP_PUSH);
  assign pq_pop_o     = (gnt_op == OP_POP);
  assign pq_drop_o    = (gnt_op == OP_DROP);
  assign pq_data_o    = pq_push_o ? data_sel : '0;
  assign pq_drop_id_o = pq_drop_o ? drop_sel : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Stage 0 captures the grant; the tail lines up with the queue's response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < RESP_LAT; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= '{vld: gnt_any, idx: gnt_idx, op: gnt_op};
      for (int k = 1; k < RESP_LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  assign tag_tail = tag_p[RESP_LAT-1];

  always_comb begin
    rsp_vld_d  = '0;
    rsp_id_d   = '0;
    rsp_data_d = '0;
    if (tag_tail.vld && tag_tail.op == OP_PUSH) begin
      rsp_vld_d[tag_tail.idx] = 1'b1;
      rsp_id_d                = pq_push_id_i;
    end else if (tag_tail.vld && tag_tail.op == OP_POP) begin
      rsp_vld_d[tag_tail.idx] = 1'b1;
      rsp_data_d              = pq_data_i;
    end
  end

  // Response register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_o  <= '0;
      rsp_id_o   <= '0;
      rsp_data_o <= '0;
    end else begin
      rsp_vld_o  <= rsp_vld_d;
      rsp_id_o   <= rsp_id_d;
      rsp_data_o <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_pq_req_arbiter.sv
// Bench for pq_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_pq_req_arbiter;
  import pq_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int L     = 3;
  localparam int ID_W  = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst_ni;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ*2-1:0]    req_op;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*ID_W-1:0] req_drop_id;
  logic [NREQ-1:0]      req_rdy_o;
  logic [NREQ-1:0]      rsp_vld_o;
  logic [ID_W-1:0]      rsp_id_o;
  logic [DW-1:0]        rsp_data_o;
  logic                 pq_push_o, pq_pop_o, pq_drop_o;
  logic [ID_W-1:0]      pq_drop_id_o;
  logic [DW-1:0]        pq_data_o;
  logic                 push_rdy, pop_rdy, drop_rdy, empty;
  logic [ID_W-1:0]      pq_push_id;
  logic [DW-1:0]        pq_data;

  pq_req_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .RESP_LAT(L)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_vld_i     (req_vld),
    .req_op_i      (req_op),
    .req_data_i    (req_data),
    .req_drop_id_i (req_drop_id),
    .req_rdy_o     (req_rdy_o),
    .rsp_vld_o     (rsp_vld_o),
    .rsp_id_o      (rsp_id_o),
    .rsp_data_o    (rsp_data_o),
    .pq_push_o     (pq_push_o),
    .pq_pop_o      (pq_pop_o),
    .pq_drop_o     (pq_drop_o),
    .pq_drop_id_o  (pq_drop_id_o),
    .pq_data_o     (pq_data_o),
    .pq_push_rdy_i (push_rdy),
    .pq_pop_rdy_i  (pop_rdy),
    .pq_drop_rdy_i (drop_rdy),
    .pq_empty_i    (empty),
    .pq_push_id_i  (pq_push_id),
    .pq_data_i     (pq_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int idx;
    int op;
  } pend_t;

  pend_t           pend[$];
  int              mptr = 0;
  int              cyc = 0;
  int              rsp_cnt[NREQ];
  logic [NREQ-1:0] last_rdy = '0;
  logic [ID_W-1:0] hist_id[64];
  logic [DW-1:0]   hist_data[64];

  int              eg, gop, rkind, j;
  logic [NREQ-1:0] exp_rdy, exp_rsp;
  logic [2:0]      exp_strb;
  logic [DW-1:0]   exp_data, exp_rdata;
  logic [ID_W-1:0] exp_drop, exp_id;

  function automatic bit m_elig(int r);
    int op;
    op = int'(req_op[2*r +: 2]);
    if (!req_vld[r]) return 1'b0;
    case (op)
      1: return push_rdy;
      2: return pop_rdy && !empty;
      3: return drop_rdy;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      mptr = 0;
      pend.delete();
      chk("rst_rdy", 64'(req_rdy_o), 64'(0));
      chk("rst_strobes", 64'({pq_push_o, pq_pop_o, pq_drop_o}), 64'(0));
      chk("rst_rsp_vld", 64'(rsp_vld_o), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id_o), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data_o), 64'(0));
    end else begin
      eg = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (eg < 0 && m_elig(j)) eg = j;
      end
      exp_rdy = '0; exp_strb = '0; exp_data = '0; exp_drop = '0; gop = 0;
      if (eg >= 0) begin
        exp_rdy[eg] = 1'b1;
        gop = int'(req_op[2*eg +: 2]);
        exp_strb = (gop == 1) ? 3'b100 : (gop == 2) ? 3'b010 : 3'b001;
        if (gop == 1) exp_data = req_data[eg*DW +: DW];
        if (gop == 3) exp_drop = req_drop_id[eg*ID_W +: ID_W];
      end
      chk("grant", 64'(req_rdy_o), 64'(exp_rdy));
      chk("strobes", 64'({pq_push_o, pq_pop_o, pq_drop_o}), 64'(exp_strb));
      chk("pq_data", 64'(pq_data_o), 64'(exp_data));
      chk("pq_drop_id", 64'(pq_drop_id_o), 64'(exp_drop));

      exp_rsp = '0; rkind = 0; exp_id = '0; exp_rdata = '0;
      for (int p = pend.size() - 1; p >= 0; p--) begin
        if (pend[p].due == cyc) begin
          exp_rsp[pend[p].idx] = 1'b1;
          rkind = pend[p].op;
          exp_id = hist_id[(cyc - 1) % 64];
          exp_rdata = hist_data[(cyc - 1) % 64];
          pend.delete(p);
        end
      end
      chk("rsp_vld", 64'(rsp_vld_o), 64'(exp_rsp));
      if (rkind == 1) chk("rsp_id", 64'(rsp_id_o), 64'(exp_id));
      if (rkind == 2) chk("rsp_data", 64'(rsp_data_o), 64'(exp_rdata));

      if (eg >= 0) begin
        if (gop == 1 || gop == 2) pend.push_back('{due: cyc + L + 1, idx: eg, op: gop});
        mptr = (eg + 1) % NREQ;
      end
    end
    last_rdy = req_rdy_o;
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] += int'(rsp_vld_o[i]);
    hist_id[cyc % 64]   = pq_push_id;
    hist_data[cyc % 64] = pq_data;
    cyc++;
  end

  // ---------------- stimulus ----------------
  bit hold_pq = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_pq) begin
      pq_push_id = ID_W'($urandom);
      pq_data    = $urandom;
    end
  endtask

  task automatic set_req(input int i, input bit v, input int op,
                         input logic [DW-1:0] d, input logic [ID_W-1:0] id);
    req_vld[i]                  = v;
    req_op[2*i +: 2]            = 2'(op);
    req_data[i*DW +: DW]        = d;
    req_drop_id[i*ID_W +: ID_W] = id;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
  endtask

  function automatic int cnt_sum();
    int s;
    s = 0;
    for (int i = 0; i < NREQ; i++) s += rsp_cnt[i];
    return s;
  endfunction

  initial begin
    rst_ni = 1'b0;
    req_vld = '0; req_op = '0; req_data = '0; req_drop_id = '0;
    push_rdy = 1'b1; pop_rdy = 1'b1; drop_rdy = 1'b1; empty = 1'b0;
    pq_push_id = '0; pq_data = '0;
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;

    // Reset held with every requester pushing
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1, DW'(32'h100 + i), '0);
    repeat (3) begin
      step(); #2;
      chk("t1_rdy_in_reset", 64'(req_rdy_o), 64'(0));
      chk("t1_push_in_reset", 64'(pq_push_o), 64'(0));
      chk("t1_rsp_in_reset", 64'(rsp_vld_o), 64'(0));
    end
    step(); rst_ni = 1'b1; #2;
    chk("t1_first_grant", 64'(req_rdy_o), 64'(4'b0001));

    // Fairness: all push, always ready
    step(); rst_ni = 1'b0; req_vld = '0;
    step(); rst_ni = 1'b1; clr_cnt();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1, $urandom, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      req_vld = '1;
      #2;
      chk("t2_rr_order", 64'(req_rdy_o), 64'(1) << (k % 4));
    end
    step(); req_vld = '0;
    repeat (L + 2) step();
    for (int i = 0; i < NREQ; i++) chk("t2_rsp_count", 64'(rsp_cnt[i]), 64'(2));

    // Empty queue: POP skipped, PUSH proceeds
    step(); rst_ni = 1'b0;
    step(); rst_ni = 1'b1; empty = 1'b1;
    set_req(0, 1'b1, 2, '0, '0);
    set_req(1, 1'b1, 1, 32'hCAFE0001, '0);
    #2;
    chk("t3_push_past_pop", 64'(req_rdy_o), 64'(4'b0010));
    step(); req_vld[1] = 1'b0; #2;
    chk("t3_pop_waits", 64'(req_rdy_o), 64'(0));
    step(); empty = 1'b0; #2;
    chk("t3_pop_granted", 64'(req_rdy_o), 64'(4'b0001));
    chk("t3_pop_strobe", 64'(pq_pop_o), 64'(1));
    step(); req_vld = '0;
    repeat (L + 2) step();

    // Ready gating: push blocked, drop proceeds without response
    push_rdy = 1'b0; clr_cnt();
    set_req(2, 1'b1, 1, 32'h22, '0);
    set_req(3, 1'b1, 3, '0, 5'd5);
    #2;
    chk("t4_drop_only", 64'(req_rdy_o), 64'(4'b1000));
    chk("t4_drop_id", 64'(pq_drop_id_o), 64'(5));
    chk("t4_drop_strobe", 64'(pq_drop_o), 64'(1));
    step(); req_vld[3] = 1'b0; #2;
    chk("t4_push_blocked", 64'(req_rdy_o), 64'(0));
    step(); req_vld = '0; push_rdy = 1'b1;
    repeat (L + 3) step();
    chk("t4_no_rsp", 64'(cnt_sum()), 64'(0));

    // Latency: POP from requester 1, response after L+1 cycles
    hold_pq = 1'b1; pq_data = 32'hABCD0123;
    step(); set_req(1, 1'b1, 2, '0, '0); #2;
    chk("t5_grant", 64'(req_rdy_o), 64'(4'b0010));
    step(); req_vld = '0; #2;
    chk("t5_rsp_t1", 64'(rsp_vld_o), 64'(0));
    step(); #2;
    chk("t5_rsp_t2", 64'(rsp_vld_o), 64'(0));
    step(); #2;
    chk("t5_rsp_t3", 64'(rsp_vld_o), 64'(0));
    step(); #2;
    chk("t5_rsp_t4", 64'(rsp_vld_o), 64'(4'b0010));
    chk("t5_rsp_data", 64'(rsp_data_o), 64'(32'hABCD0123));
    hold_pq = 1'b0;

    // Reset while a POP is in flight
    step(); set_req(1, 1'b1, 2, '0, '0); #2;
    chk("t6_grant", 64'(req_rdy_o), 64'(4'b0010));
    step(); req_vld = '0; rst_ni = 1'b0; clr_cnt();
    step();
    step(); rst_ni = 1'b1;
    repeat (6) step();
    chk("t6_no_rsp", 64'(cnt_sum()), 64'(0));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_ni   = ($urandom_range(0, 499) != 0);
      push_rdy = ($urandom_range(0, 9) != 0);
      pop_rdy  = ($urandom_range(0, 9) != 0);
      drop_rdy = ($urandom_range(0, 9) != 0);
      empty    = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (last_rdy[i] || !req_vld[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, int'($urandom_range(0, 3)), $urandom, ID_W'($urandom));
          else
            req_vld[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          req_vld[i] = 1'b0;
        end
      end
    end
    step(); req_vld = '0; rst_ni = 1'b1;
    repeat (L + 3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
